llr_pair_scheduler: RTL and testbench

Upstream feeder for the LLR f/g processing element at the top level of the SC polar decoder. It accepts one frame of N channel LLRs over a valid/ready stream and saturates them to DATA_WIDTH. It then issues the N/2 (a,b) pairs twice: first as an f pass (sel=1), then as a g pass (sel=0), using partial-sum bits returned from the left-subtree decision logic.

---
 rtl/llr_pair_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_llr_pair_scheduler.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/llr_pair_scheduler.sv
// llr_pair_scheduler: buffers one frame of channel LLRs, saturates each one, and
// feeds the f/g processing element with (a,b) pairs. The f pass runs first;
// the g pass follows once the left-subtree partial sums arrive.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_LOAD    | accepting in_llr samples into L[0..N-1]
// S_F_PASS  | issuing (L[i], L[i+N/2]) with sel=1, us=0
// S_WAIT_US | waiting for the partial-sum vector from decision logic
// S_G_PASS  | issuing (L[i], L[i+N/2]) with sel=0, us=us_vec[i]
module llr_pair_scheduler #(
  parameter  int DATA_WIDTH = 8,
  parameter  int IN_WIDTH   = 10,
  parameter  int N          = 8,
  localparam int PW         = (N > 2) ? $clog2(N/2) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [IN_WIDTH-1:0]   in_llr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N/2-1:0]               us_vec,
  input  logic                         us_valid,
  output logic                         us_ready,
  output logic signed [DATA_WIDTH-1:0] a,
  output logic signed [DATA_WIDTH-1:0] b,
  output logic                         us,
  output logic                         sel,
  output logic [PW-1:0]                pair_idx,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         done
);

  localparam int CW   = $clog2(N);
  localparam int HALF = N / 2;

  // Symmetric clamp bounds; -2^(DW-1) is folded onto -(2^(DW-1)-1).
  localparam logic signed [IN_WIDTH-1:0] SAT_HI = IN_WIDTH'((1 << (DATA_WIDTH-1)) - 1);
  localparam logic signed [IN_WIDTH-1:0] SAT_LO = -SAT_HI;

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_F_PASS  = 2'd1,
    S_WAIT_US = 2'd2,
    S_G_PASS  = 2'd3
  } state_t;

  state_t                       r_state;
  logic signed [DATA_WIDTH-1:0] r_llr [N];
  logic [CW-1:0]                r_cnt;
  logic [HALF-1:0]              r_us_vec;
  logic signed [DATA_WIDTH-1:0] r_a;
  logic signed [DATA_WIDTH-1:0] r_b;
  logic                         r_us;
  logic                         r_sel;
  logic [PW-1:0]                r_pair_idx;
  logic                         r_out_valid;
  logic                         r_done;

  logic                         w_in_fire;
  logic                         w_out_fire;
  logic                         w_last_pair;
  logic signed [DATA_WIDTH-1:0] w_sat;
  logic signed [DATA_WIDTH-1:0] w_llr_nxt [N];
  logic [PW-1:0]                w_rd_idx;
  logic [CW-1:0]                w_rd_lo;
  logic [CW-1:0]                w_rd_hi;

  assign in_ready  = (r_state == S_LOAD);
  assign us_ready  = (r_state == S_WAIT_US);
  assign busy      = (r_state != S_LOAD);
  assign a         = r_a;
  assign b         = r_b;
  assign us        = r_us;
  assign sel       = r_sel;
  assign pair_idx  = r_pair_idx;
  assign out_valid = r_out_valid;
  assign done      = r_done;

  assign w_in_fire   = in_valid && (r_state == S_LOAD);
  assign w_out_fire  = r_out_valid && out_ready;
  assign w_last_pair = (r_pair_idx == PW'(HALF - 1));

  // Next pair to present: index 0 when a pass starts, otherwise current + 1.
  assign w_rd_idx = ((r_state == S_F_PASS) || (r_state == S_G_PASS)) ? r_pair_idx + 1'b1 : '0;
  assign w_rd_lo  = CW'(w_rd_idx);
  assign w_rd_hi  = w_rd_lo + CW'(HALF);

  // Clamp the incoming channel LLR into the symmetric DATA_WIDTH range.
  always_comb begin
    if (in_llr > SAT_HI)
      w_sat = DATA_WIDTH'(SAT_HI);
    else if (in_llr < SAT_LO)
      w_sat = DATA_WIDTH'(SAT_LO);
    else
      w_sat = DATA_WIDTH'(in_llr);
  end

  // Buffer view including the sample being written this cycle, so the first
  // f pair can be registered on the same edge as the last load.
  always_comb begin
    w_llr_nxt = r_llr;
    if (w_in_fire)
      w_llr_nxt[r_cnt] = w_sat;
  end

  // Main controller: load buffer, run f pass, wait for partial sums, run g pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_LOAD;
      r_cnt       <= '0;
      r_us_vec    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_us        <= 1'b0;
      r_sel       <= 1'b0;
      r_pair_idx  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      for (int k = 0; k < N; k++)
        r_llr[k] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (w_in_fire) begin
            r_llr[r_cnt] <= w_sat;
            if (r_cnt == CW'(N - 1)) begin
              r_cnt       <= '0;
              r_state     <= S_F_PASS;
              r_out_valid <= 1'b1;
              r_sel       <= 1'b1;
              r_us        <= 1'b0;
              r_pair_idx  <= '0;
              r_a         <= w_llr_nxt[w_rd_lo];
              r_b         <= w_llr_nxt[w_rd_hi];
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_F_PASS: begin
          if (w_out_fire) begin
            if (w_last_pair) begin
              r_out_valid <= 1'b0;
              r_pair_idx  <= '0;
              r_state     <= S_WAIT_US;
            end else begin
              r_pair_idx <= w_rd_idx;
              r_a        <= w_llr_nxt[w_rd_lo];
              r_b        <= w_llr_nxt[w_rd_hi];
            end
          end
        end
        S_WAIT_US: begin
          if (us_valid) begin
            r_us_vec    <= us_vec;
            r_state     <= S_G_PASS;
            r_out_valid <= 1'b1;
            r_sel       <= 1'b0;
            r_pair_idx  <= '0;
            r_us        <= us_vec[0];
            r_a         <= w_llr_nxt[w_rd_lo];
            r_b         <= w_llr_nxt[w_rd_hi];
          end
        end
        S_G_PASS: begin
          if (w_out_fire) begin
            if (w_last_pair) begin
              r_out_valid <= 1'b0;
              r_pair_idx  <= '0;
              r_us        <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= S_LOAD;
            end else begin
              r_pair_idx <= w_rd_idx;
              r_us       <= r_us_vec[w_rd_idx];
              r_a        <= w_llr_nxt[w_rd_lo];
              r_b        <= w_llr_nxt[w_rd_hi];
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_llr_pair_scheduler.sv
// Directed bench for llr_pair_scheduler (DW=8, IN=10, N=8). Inputs are driven
// and outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_llr_pair_scheduler;

  logic              clk;
  logic              rst_n;
  logic signed [9:0] in_llr;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        us_vec;
  logic              us_valid;
  logic              us_ready;
  logic signed [7:0] a;
  logic signed [7:0] b;
  logic              us;
  logic              sel;
  logic [1:0]        pair_idx;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  int n_err;
  int n_chk;

  llr_pair_scheduler #(.DATA_WIDTH(8), .IN_WIDTH(10), .N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_llr    (in_llr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .us_vec    (us_vec),
    .us_valid  (us_valid),
    .us_ready  (us_ready),
    .a         (a),
    .b         (b),
    .us        (us),
    .sel       (sel),
    .pair_idx  (pair_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_a"}, a, 0);
    chk({tag, "_b"}, b, 0);
    chk({tag, "_us"}, us, 0);
    chk({tag, "_sel"}, sel, 0);
    chk({tag, "_idx"}, pair_idx, 0);
    chk({tag, "_oval"}, out_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_usrdy"}, us_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_inrdy"}, in_ready, 1);
  endtask

  task automatic load_frame(input int v[8], input bit keep_valid);
    for (int i = 0; i < 8; i++) begin
      chk("in_ready_load", in_ready, 1);
      in_valid = 1'b1;
      in_llr   = 10'(v[i]);
      @(negedge clk);
    end
    if (keep_valid) in_llr = 10'(99);
    else            in_valid = 1'b0;
  endtask

  // Walks a pass, checking every presented pair, until 'stop' transfers happen.
  task automatic run_pass(input int ea[4], input int eb[4], input int eus[4],
                          input int esel, input int rdy[8], input int stop);
    int idx;
    int k;
    idx = 0;
    k   = 0;
    while (idx < stop && k < 40) begin
      chk("out_valid", out_valid, 1);
      chk("pair_idx", pair_idx, idx);
      chk("a", a, ea[idx]);
      chk("b", b, eb[idx]);
      chk("sel", sel, esel);
      chk("us", us, eus[idx]);
      chk("in_ready_pass", in_ready, 0);
      chk("done_pass", done, 0);
      out_ready = (rdy[k % 8] != 0);
      @(negedge clk);
      if (out_ready) idx++;
      k++;
    end
    if (idx < stop) chk("pass_timeout", idx, stop);
  endtask

  int all_rdy[8] = '{1, 1, 1, 1, 1, 1, 1, 1};
  int bp_rdy[8]  = '{1, 0, 0, 1, 0, 1, 1, 1};
  int zero4[4]   = '{0, 0, 0, 0};

  int l1[8]   = '{10, -20, 30, -40, 50, -60, 70, -80};
  int l1_a[4] = '{10, -20, 30, -40};
  int l1_b[4] = '{50, -60, 70, -80};
  int l1_us[4] = '{0, 1, 0, 1};

  int l2[8]   = '{300, -300, -128, 127, -127, 0, 1, -1};
  int l2_a[4] = '{127, -127, -127, 127};
  int l2_b[4] = '{-127, 0, 1, -1};
  int l2_us[4] = '{1, 0, 1, 0};

  int l3[8]   = '{5, -6, 7, -8, 9, -10, 11, -12};
  int l3_a[4] = '{5, -6, 7, -8};
  int l3_b[4] = '{9, -10, 11, -12};
  int l3_us[4] = '{1, 1, 0, 0};

  int l4[8]   = '{-3, 4, -100, 100, 200, -200, 0, 2};
  int l4_a[4] = '{-3, 4, -100, 100};
  int l4_b[4] = '{127, -127, 0, 2};

  initial begin
    n_err     = 0;
    n_chk     = 0;
    rst_n     = 1'b0;
    in_llr    = '0;
    in_valid  = 1'b0;
    us_vec    = '0;
    us_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("post_rst");

    // Frame 1: f pass at full rate, then g pass with us_vec=1010.
    load_frame(l1, 1'b0);
    run_pass(l1_a, l1_b, zero4, 1, all_rdy, 4);
    chk("f1_end_oval", out_valid, 0);
    chk("f1_end_usrdy", us_ready, 1);
    chk("f1_end_busy", busy, 1);
    us_vec   = 4'b1010;
    us_valid = 1'b1;
    @(negedge clk);
    us_valid = 1'b0;
    chk("g1_usrdy", us_ready, 0);
    run_pass(l1_a, l1_b, l1_us, 0, all_rdy, 4);
    chk("g1_end_oval", out_valid, 0);
    chk("g1_end_done", done, 1);
    chk("g1_end_inrdy", in_ready, 1);
    chk("g1_end_busy", busy, 0);
    @(negedge clk);
    chk("g1_done_once", done, 0);

    // Frame 2: saturation plus backpressure, reset in the middle of the g pass.
    load_frame(l2, 1'b0);
    run_pass(l2_a, l2_b, zero4, 1, bp_rdy, 4);
    chk("f2_end_oval", out_valid, 0);
    chk("f2_end_usrdy", us_ready, 1);
    out_ready = 1'b1;
    us_vec    = 4'b0101;
    us_valid  = 1'b1;
    @(negedge clk);
    us_valid = 1'b0;
    run_pass(l2_a, l2_b, l2_us, 0, all_rdy, 2);
    chk("g2_at_idx2", pair_idx, 2);
    chk("g2_at_oval", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_inrdy", in_ready, 1);

    // Frame 3: in_valid stays high and us_valid is pulsed during the f pass.
    load_frame(l3, 1'b1);
    out_ready = 1'b0;
    us_vec    = 4'b1111;
    us_valid  = 1'b1;
    @(negedge clk);
    us_valid = 1'b0;
    chk("f3_us_ignored_usrdy", us_ready, 0);
    run_pass(l3_a, l3_b, zero4, 1, all_rdy, 4);
    chk("f3_end_usrdy", us_ready, 1);
    chk("f3_end_oval", out_valid, 0);
    chk("f3_end_inrdy", in_ready, 0);
    us_vec   = 4'b0011;
    us_valid = 1'b1;
    @(negedge clk);
    us_valid = 1'b0;
    run_pass(l3_a, l3_b, l3_us, 0, all_rdy, 4);
    chk("g3_end_done", done, 1);
    chk("g3_end_inrdy", in_ready, 1);

    // Frame 4 begins on the very cycle done is seen.
    load_frame(l4, 1'b0);
    run_pass(l4_a, l4_b, zero4, 1, all_rdy, 4);
    chk("f4_end_usrdy", us_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
